npcnn_result_reader: RTL
========================

Name: npcnn_result_reader

Overview:
- Sink-side companion to the npcnn convolution engine.
- Captures the engine's 20-bit signed result stream into an internal buffer, with optional ReLU applied on write.
- Hands the stored feature map to a host in raster order through a request/valid read handshake.
- Sits between the npcnn output port and the host or the next layer's loader.

Parameters:
a_size, 6, input activation map edge length (must match the engine)
f_size, 3, filter edge length
stride, 1, convolution stride
zeropadding, 0, zero-pad width per side
relu, 1, 1 = clamp negative results to 0 on write; 0 = store raw
(derived) o_size = (a_size + 2*zeropadding - f_size)/stride + 1; depth = o_size*o_size (defaults: 4, 16)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; arms a new capture
in_data  input  20  signed two's-complement conv result
in_valid  input  1  in_data valid this cycle
in_done  input  1  engine done; no further results for this frame
rd_req  input  1  host requests the next stored word
rd_data  output  20  stored result; registered
rd_valid  output  1  one-cycle strobe, rd_data valid
rd_last  output  1  asserted with rd_valid on the final word
ready  output  1  frame captured, readable (level)
busy  output  1  state is COLLECT or READY
overflow  output  1  sticky: result arrived while not collecting
count  output  10  number of words captured this frame

Behaviour:
- Reset (async) values:
  - State goes to IDLE.
  - rd_data=0, rd_valid=0, rd_last=0, ready=0, busy=0, overflow=0, count=0.
  - Write and read pointers are 0.
  - Buffer contents are don't-care.
- States: IDLE, COLLECT, READY.
- IDLE:
  - start: go to COLLECT; clear count, write pointer, read pointer and overflow.
  - in_valid in IDLE: sets overflow; data is dropped.
  - rd_req in IDLE is ignored.
- COLLECT:
  - Each in_valid cycle writes (relu && in_data[19]) ? 0 : in_data to mem[count], then count increments.
  - When the write that makes count==depth occurs, the next state is READY.
  - in_done with count<depth: go to READY (short frame).
  - in_valid together with in_done in the same cycle: the word is written first, then READY.
  - in_done with count==0 (no valid words): return to IDLE, ready stays 0.
  - start and rd_req are ignored in COLLECT.
- READY:
  - ready=1.
  - rd_req: on the next cycle, rd_data=mem[rd_ptr] and rd_valid=1 for exactly one cycle; rd_ptr increments.
  - rd_last=1 with the word at rd_ptr==count-1. On that same cycle ready drops and the state returns to IDLE.
  - Back-to-back rd_req on consecutive cycles is legal: one word per cycle, latency 1.
  - rd_req arriving on the cycle the last word is returned is ignored.
  - in_valid in READY sets overflow and does not alter the buffer or count.
  - start in READY is ignored; the frame must be drained first.
- rd_data holds its last value when rd_valid=0.
- overflow is cleared only by reset or by the start that is accepted in IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; partial frame is discarded.
- count saturates at depth; it never wraps.

Test Plan:
1. Defaults, relu=1: start, then 16 in_valid with values -8..7 and in_done on the 16th → ready=1, count=16. 16 back-to-back rd_req return 0×8 then 0..7, rd_last on word 16, then ready=0.
2. relu=0: same stimulus → reads return -8..7 exactly (e.g. 0xFFFF8 for -8).
3. Short frame: start, 5 valids (100..104), then in_done alone → count=5; reads return 100..104 with rd_last on 104, then IDLE.
4. Overflow: after frame 1 is captured, 1 extra in_valid in READY → overflow=1 and buffer unchanged on readback. A new start after draining clears overflow.
5. Reset mid-COLLECT after 7 words → all outputs 0. A new frame captures cleanly from count=0.
6. in_done with no samples → returns to IDLE, ready never asserts. rd_req in IDLE produces no rd_valid.

Source files
------------

// File: rtl/npcnn_result_reader_if.sv
// rtl/npcnn_result_reader_if.sv - engine result stream, host read handshake and status bundle
interface npcnn_result_reader_if;
  logic        start;
  logic [19:0] in_data;
  logic        in_valid;
  logic        in_done;
  logic        rd_req;
  logic [19:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        ready;
  logic        busy;
  logic        overflow;
  logic [9:0]  count;

  modport master (
    output start, in_data, in_valid, in_done, rd_req,
    input  rd_data, rd_valid, rd_last, ready, busy, overflow, count
  );

  modport slave (
    input  start, in_data, in_valid, in_done, rd_req,
    output rd_data, rd_valid, rd_last, ready, busy, overflow, count
  );
endinterface

// File: rtl/npcnn_result_reader.sv
// rtl/npcnn_result_reader.sv - captures a conv result frame (optional ReLU) and replays it to a host
module npcnn_result_reader #(
  parameter int a_size      = 6,
  parameter int f_size      = 3,
  parameter int stride      = 1,
  parameter int zeropadding = 0,
  parameter int relu        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  npcnn_result_reader_if.slave  bus
);
  localparam int o_size = (a_size + 2 * zeropadding - f_size) / stride + 1;
  localparam int depth  = o_size * o_size;
  localparam int aw     = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [9:0] depth_c = 10'(depth);

  typedef enum logic [1:0] {IDLE, COLLECT, READY} state_t;

  state_t      state, state_next;
  logic [19:0] mem [depth];
  logic [9:0]  count_q;
  logic [9:0]  rd_ptr;
  logic [19:0] rd_data_q;
  logic        rd_valid_q, rd_last_q, overflow_q;
  logic        wr_en, rd_en, rd_end;
  logic [19:0] wr_word;

  // count doubles as the write pointer; it stops at depth so it never wraps
  always_comb begin
    wr_en   = (state == COLLECT) && bus.in_valid && (count_q < depth_c);
    rd_en   = (state == READY) && bus.rd_req;
    rd_end  = rd_en && (rd_ptr == count_q - 10'd1);
    wr_word = ((relu != 0) && bus.in_data[19]) ? 20'd0 : bus.in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) state_next = COLLECT;
      end
      COLLECT: begin
        if (wr_en && (count_q == depth_c - 10'd1))
          state_next = READY;
        else if (bus.in_done)
          state_next = (count_q == 10'd0 && !wr_en) ? IDLE : READY;
      end
      READY: begin
        if (rd_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      rd_ptr     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            count_q    <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
          end else if (bus.in_valid) begin
            overflow_q <= 1'b1;
          end
        end
        COLLECT: begin
          if (wr_en) count_q <= count_q + 10'd1;
        end
        READY: begin
          if (bus.in_valid) overflow_q <= 1'b1;
          if (rd_en) begin
            rd_data_q  <= mem[rd_ptr[aw-1:0]];
            rd_valid_q <= 1'b1;
            rd_last_q  <= rd_end;
            rd_ptr     <= rd_ptr + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // buffer contents are don't-care after reset, so no reset branch here
  always_ff @(posedge clk) begin
    if (wr_en) mem[count_q[aw-1:0]] <= wr_word;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.ready    = (state == READY);
  assign bus.busy     = (state != IDLE);
  assign bus.overflow = overflow_q;
  assign bus.count    = count_q;
endmodule
